// File: rtl/axis_video_crop_if.sv
// AXI4-Stream video bus: pixel data plus SOF (tuser) and EOL (tlast) markers.
// The master modport drives the beat and the slave modport returns tready.
interface axis_video_crop_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tuser;
  logic                  tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);

endinterface

// File: rtl/axis_video_crop.sv
// AXI4-Stream video window cropper.
// It forwards only the pixels inside a rectangular window and regenerates SOF
// and EOL for the cropped frame. There is one output register stage.
// Optional macro AXIS_VIDEO_CROP_RUNTIME_EN adds the win_* ports. Those ports
// are sampled into shadow registers on every accepted SOF beat.
module axis_video_crop #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 12,
  parameter int X_START    = 0,
  parameter int Y_START    = 0,
  parameter int OUT_W      = 640,
  parameter int OUT_H      = 480
) (
  input  logic                 aclk,
  input  logic                 rst,
  input  logic                 aclken,
  axis_video_crop_if.slave     s_axis_video,
  axis_video_crop_if.master    m_axis_video,
`ifdef AXIS_VIDEO_CROP_RUNTIME_EN
  input  logic [CNT_WIDTH-1:0] win_x_start,
  input  logic [CNT_WIDTH-1:0] win_y_start,
  input  logic [CNT_WIDTH-1:0] win_w,
  input  logic [CNT_WIDTH-1:0] win_h,
`endif
  output logic                 sync_err
);

  localparam int CW1 = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0]  x_q, y_q, cur_x, cur_y;
  logic [CNT_WIDTH-1:0]  win_x, win_y, win_wd, win_ht;
  logic [CW1-1:0]        x_e, y_e, wx, wy, wx_end, wy_end;
  logic                  s_ready, accept, sof_in, take_beat, resync;
  logic                  in_win, out_sof, out_eol, load_out;

  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q, m_user_q, m_last_q, sync_err_q;

  assign s_ready               = aclken & (~m_valid_q | m_axis_video.tready);
  assign s_axis_video.tready   = s_ready;
  assign accept                = s_axis_video.tvalid & s_ready;
  assign sof_in                = accept & s_axis_video.tuser;

  assign m_axis_video.tdata    = m_data_q;
  assign m_axis_video.tvalid   = m_valid_q;
  assign m_axis_video.tuser    = m_user_q;
  assign m_axis_video.tlast    = m_last_q;
  assign sync_err              = sync_err_q;

`ifdef AXIS_VIDEO_CROP_RUNTIME_EN
  logic [CNT_WIDTH-1:0] sh_x, sh_y, sh_w, sh_h;

  // Capture the runtime window on each accepted SOF so it stays fixed for the whole frame
  always_ff @(posedge aclk) begin
    if (rst) begin
      sh_x <= CNT_WIDTH'(X_START);
      sh_y <= CNT_WIDTH'(Y_START);
      sh_w <= CNT_WIDTH'(OUT_W);
      sh_h <= CNT_WIDTH'(OUT_H);
    end else if (sof_in) begin
      sh_x <= win_x_start;
      sh_y <= win_y_start;
      sh_w <= win_w;
      sh_h <= win_h;
    end
  end

  // The SOF beat itself already uses the newly presented window
  always_comb begin
    win_x  = sof_in ? win_x_start : sh_x;
    win_y  = sof_in ? win_y_start : sh_y;
    win_wd = sof_in ? win_w       : sh_w;
    win_ht = sof_in ? win_h       : sh_h;
  end
`else
  assign win_x  = CNT_WIDTH'(X_START);
  assign win_y  = CNT_WIDTH'(Y_START);
  assign win_wd = CNT_WIDTH'(OUT_W);
  assign win_ht = CNT_WIDTH'(OUT_H);
`endif

  // State register: leaves WAIT_SOF only on the first accepted SOF
  always_ff @(posedge aclk) begin
    if (rst) state_q <= WAIT_SOF;
    else if (aclken) state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q == WAIT_SOF && sof_in) state_d = ACTIVE;
  end

  // Beat decode: an SOF beat restarts the frame at (0,0), and window tests use one extra bit
  always_comb begin
    take_beat = accept & ((state_q == ACTIVE) | s_axis_video.tuser);
    resync    = sof_in & (state_q == ACTIVE) & ((x_q != '0) | (y_q != '0));
    cur_x     = s_axis_video.tuser ? '0 : x_q;
    cur_y     = s_axis_video.tuser ? '0 : y_q;
    x_e       = {1'b0, cur_x};
    y_e       = {1'b0, cur_y};
    wx        = {1'b0, win_x};
    wy        = {1'b0, win_y};
    wx_end    = wx + {1'b0, win_wd};
    wy_end    = wy + {1'b0, win_ht};
    in_win    = (x_e >= wx) & (x_e < wx_end) & (y_e >= wy) & (y_e < wy_end);
    out_sof   = in_win & (x_e == wx) & (y_e == wy);
    out_eol   = in_win & ((x_e == wx_end - CW1'(1)) | s_axis_video.tlast);
    load_out  = take_beat & in_win;
  end

  // Pixel position counters saturate so that a missing EOL never wraps back into the window
  always_ff @(posedge aclk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (aclken && take_beat) begin
      if (s_axis_video.tlast) begin
        x_q <= '0;
        y_q <= (cur_y == CNT_MAX) ? cur_y : cur_y + 1'b1;
      end else begin
        x_q <= (cur_x == CNT_MAX) ? cur_x : cur_x + 1'b1;
        y_q <= cur_y;
      end
    end
  end

  // Output register loads in-window beats and holds them while downstream stalls
  always_ff @(posedge aclk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_user_q  <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (aclken) begin
      if (load_out) begin
        m_valid_q <= 1'b1;
        m_data_q  <= s_axis_video.tdata;
        m_user_q  <= out_sof;
        m_last_q  <= out_eol;
      end else if (m_axis_video.tready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  // One-cycle resync pulse
  always_ff @(posedge aclk) begin
    if (rst) sync_err_q <= 1'b0;
    else if (aclken) sync_err_q <= resync;
  end

endmodule

// File: tb/tb_axis_video_crop.sv
// Directed testbench for axis_video_crop.
// The input is an 8x4 frame whose tdata holds the {y,x} nibbles.
// The crop window is x 2..5 and y 1..2.
module tb_axis_video_crop;

  logic aclk = 1'b0;
  logic rst;
  logic aclken;
  logic sync_err;

  always #5 aclk = ~aclk;

  axis_video_crop_if #(.DATA_WIDTH(16)) s_if ();
  axis_video_crop_if #(.DATA_WIDTH(16)) m_if ();

`ifdef AXIS_VIDEO_CROP_RUNTIME_EN
  logic [11:0] win_x_start = 12'd2;
  logic [11:0] win_y_start = 12'd1;
  logic [11:0] win_w       = 12'd4;
  logic [11:0] win_h       = 12'd2;
`endif

  axis_video_crop #(
    .DATA_WIDTH(16), .CNT_WIDTH(12),
    .X_START(2), .Y_START(1), .OUT_W(4), .OUT_H(2)
  ) dut (
    .aclk(aclk),
    .rst(rst),
    .aclken(aclken),
    .s_axis_video(s_if),
    .m_axis_video(m_if),
`ifdef AXIS_VIDEO_CROP_RUNTIME_EN
    .win_x_start(win_x_start),
    .win_y_start(win_y_start),
    .win_w(win_w),
    .win_h(win_h),
`endif
    .sync_err(sync_err)
  );

  localparam logic [17:0] U = 18'h20000;
  localparam logic [17:0] L = 18'h10000;

  int          checks = 0;
  int          passes = 0;
  int          fails = 0;
  int          mode = 0;
  int          cyc = 0;
  int          syncCount = 0;
  bit          prevStall = 0;
  bit          lastAccept = 0;
  logic [17:0] prevBeat = '0;
  logic [17:0] outQ[$];
  logic [17:0] expQ[$];

  function automatic logic [17:0] ob();
    return {m_if.tuser, m_if.tlast, m_if.tdata};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one clock. Outputs are sampled at the falling edge.
  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    case (mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = ((cyc % 12) < 5) ? 1'b0 : cyc[0];
      default: m_if.tready = 1'b0;
    endcase
    @(negedge aclk);
    if (aclken) begin
      if (prevStall) begin
        checkOutput("stall_hold", ob(), prevBeat);
        checkOutput("stall_valid", m_if.tvalid, 1);
      end
      if (m_if.tvalid && !m_if.tready) checkOutput("stall_sready", s_if.tready, 0);
      if (m_if.tvalid && m_if.tready) outQ.push_back(ob());
      if (sync_err) syncCount++;
      prevStall = m_if.tvalid && !m_if.tready;
      prevBeat  = ob();
    end
    lastAccept = s_if.tvalid && s_if.tready;
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic sendBeat(input logic [15:0] d, input logic u, input logic l);
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    lastAccept  = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (lastAccept) break;
    end
    if (!lastAccept) checkOutput("accept_timeout", lastAccept, 1);
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  // Sends beats firstBeat..lastBeat of an 8x4 raster, with an optional early EOL
  task automatic applyStimulus(input int firstBeat, input int lastBeat, input bit sofFirst,
                               input int earlyRow, input int earlyX);
    for (int idx = firstBeat; idx <= lastBeat; idx++) begin
      int xx = idx % 8;
      int yy = idx / 8;
      logic [3:0] xn = xx[3:0];
      logic [3:0] yn = yy[3:0];
      if (yy == earlyRow && xx > earlyX) continue;
      sendBeat({8'h00, yn, xn}, sofFirst && (idx == firstBeat),
               (xx == 7) || (yy == earlyRow && xx == earlyX));
    end
  endtask

  task automatic drain();
    mode = 0;
    repeat (12) tick();
  endtask

  task automatic checkQueue(input string tag);
    checkOutput({tag, "_count"}, outQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++)
      if (i < outQ.size()) checkOutput($sformatf("%s_beat%0d", tag, i), outQ[i], expQ[i]);
    outQ.delete();
    expQ.delete();
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prevStall = 0;
    syncCount = 0;
    outQ.delete();
  endtask

  task automatic pushBasic();
    expQ.push_back(U | 18'h12); expQ.push_back(18'h13); expQ.push_back(18'h14); expQ.push_back(L | 18'h15);
    expQ.push_back(18'h22);     expQ.push_back(18'h23); expQ.push_back(18'h24); expQ.push_back(L | 18'h25);
  endtask

  initial begin
    rst = 1'b1;
    aclken = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = 1'b0; s_if.tlast = 1'b0;
    m_if.tready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_tvalid", m_if.tvalid, 0);
    checkOutput("rst_tdata", m_if.tdata, 0);
    checkOutput("rst_tuser", m_if.tuser, 0);
    checkOutput("rst_tlast", m_if.tlast, 0);
    checkOutput("rst_sync_err", sync_err, 0);
    checkOutput("rst_sready", s_if.tready, 1);

    $display("[TB] beats before SOF are dropped");
    applyStimulus(8, 10, 0, -1, -1);
    drain();
    checkQueue("pre_sof");

    $display("[TB] basic crop");
    doReset();
    applyStimulus(0, 31, 1, -1, -1);
    drain();
    pushBasic();
    checkQueue("basic");
    checkOutput("basic_sync", syncCount, 0);

    $display("[TB] backpressure");
    doReset();
    mode = 1;
    cyc = 0;
    applyStimulus(0, 31, 1, -1, -1);
    drain();
    pushBasic();
    checkQueue("bp");

    $display("[TB] early EOL");
    doReset();
    applyStimulus(0, 31, 1, 1, 3);
    drain();
    expQ.push_back(U | 18'h12); expQ.push_back(L | 18'h13);
    expQ.push_back(18'h22); expQ.push_back(18'h23); expQ.push_back(18'h24); expQ.push_back(L | 18'h25);
    checkQueue("early_eol");
    checkOutput("early_sync", syncCount, 0);

    $display("[TB] mid-frame resync");
    doReset();
    applyStimulus(0, 18, 1, -1, -1);
    applyStimulus(0, 31, 1, -1, -1);
    drain();
    expQ.push_back(U | 18'h12); expQ.push_back(18'h13); expQ.push_back(18'h14); expQ.push_back(L | 18'h15);
    expQ.push_back(18'h22);
    pushBasic();
    checkQueue("resync");
    checkOutput("resync_sync", syncCount, 1);

    $display("[TB] clock enable and reset mid-frame");
    doReset();
    mode = 2;
    applyStimulus(0, 10, 1, -1, -1);
    checkOutput("held_valid", m_if.tvalid, 1);
    checkOutput("held_beat", ob(), U | 18'h12);
    aclken = 1'b0;
    mode = 0;
    tick();
    tick();
    checkOutput("cken_valid", m_if.tvalid, 1);
    checkOutput("cken_sready", s_if.tready, 0);
    aclken = 1'b1;
    mode = 2;
    doReset();
    checkOutput("midrst_valid", m_if.tvalid, 0);
    mode = 0;
    applyStimulus(11, 31, 0, -1, -1);
    applyStimulus(0, 31, 1, -1, -1);
    drain();
    pushBasic();
    checkQueue("midrst");
    checkOutput("midrst_sync", syncCount, 0);

`ifdef AXIS_VIDEO_CROP_RUNTIME_EN
    $display("[TB] runtime window");
    doReset();
    applyStimulus(0, 12, 1, -1, -1);
    win_x_start = 12'd0;
    applyStimulus(13, 31, 0, -1, -1);
    applyStimulus(0, 31, 1, -1, -1);
    drain();
    pushBasic();
    expQ.push_back(U | 18'h10); expQ.push_back(18'h11); expQ.push_back(18'h12); expQ.push_back(L | 18'h13);
    expQ.push_back(18'h20);     expQ.push_back(18'h21); expQ.push_back(18'h22); expQ.push_back(L | 18'h23);
    checkQueue("runtime");
    win_x_start = 12'd2;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
